sd_block_server: RTL

Simulation-side block-device responder that services the sector request handshakes (`sd_rd`/`sd_wr`/`sd_lba`) raised by the floppy track loaders and the HDD request logic. It arbitrates between channels, asserts one-hot `sd_ack`, and streams one 512-byte sector between a flat image memory and the shared `sd_buff_*` bus. It sits directly downstream of the `emu` top level in the Verilator harness and replaces the host-side SD emulation.

---
 rtl/sd_block_server.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/sd_block_server.sv
// sd_block_server: round-robin responder for per-channel sector requests.
// Streams one 512-byte sector per grant between a flat image memory and the sd_buff_* bus.
module sd_block_server #(
  parameter int NUM_CH    = 3,
  parameter int LBA_BITS  = 16,
  parameter int ACK_DELAY = 4,
  parameter int BYTE_DIV  = 2,
  parameter int DIN_LAT   = 1,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int ADDR_W   = CH_W + LBA_BITS + 9
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic [NUM_CH-1:0]      sd_rd,
  input  logic [NUM_CH-1:0]      sd_wr,
  input  logic [NUM_CH*32-1:0]   sd_lba,
  input  logic [NUM_CH*8-1:0]    sd_buff_din,
  input  logic [NUM_CH-1:0]      img_mounted,
  output logic [NUM_CH-1:0]      sd_ack,
  output logic [8:0]             sd_buff_addr,
  output logic [7:0]             sd_buff_dout,
  output logic                   sd_buff_wr,
  output logic [ADDR_W-1:0]      img_addr,
  output logic                   img_re,
  input  logic [7:0]             img_rdata,
  output logic                   img_we,
  output logic [7:0]             img_wdata,
  output logic                   busy,
  output logic [31:0]            sectors_done
);

  localparam int PH_W  = (BYTE_DIV > 1) ? $clog2(BYTE_DIV) : 1;
  localparam int DLY_W = (ACK_DELAY > 1) ? $clog2(ACK_DELAY) : 1;

  typedef enum logic [1:0] {IDLE, DELAY, XFER, RELEASE} state_t;

  state_t              state, state_nx;
  logic [CH_W-1:0]     ch, last, grant_ch, scan;
  logic [LBA_BITS-1:0] lba;
  logic                is_rd, grant_vld, mounted, last_slot;
  logic [NUM_CH-1:0]   armed, eligible;
  logic [8:0]          byte_idx;
  logic [PH_W-1:0]     phase;
  logic [DLY_W-1:0]    dly_cnt;
  logic                unused_bits;

  assign unused_bits  = ^sd_lba;
  assign eligible     = (sd_rd | sd_wr) & armed;
  assign mounted      = img_mounted[ch];
  assign busy         = (state != IDLE);
  assign sd_buff_addr = byte_idx;
  assign img_addr     = {ch, lba, byte_idx};
  assign last_slot    = (phase == PH_W'(BYTE_DIV - 1)) && (byte_idx == 9'd511);

  // Scan from the farthest candidate to the nearest so the channel right after `last` wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = '0;
    scan      = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      scan = CH_W'((int'(last) + k) % NUM_CH);
      if (eligible[scan]) begin
        grant_vld = 1'b1;
        grant_ch  = scan;
      end
    end
  end

  always_comb begin
    state_nx     = state;
    sd_ack       = '0;
    sd_buff_wr   = 1'b0;
    sd_buff_dout = 8'h00;
    img_re       = 1'b0;
    img_we       = 1'b0;
    img_wdata    = 8'h00;
    case (state)
      IDLE:    if (grant_vld) state_nx = DELAY;
      DELAY:   if (dly_cnt == '0) state_nx = XFER;
      XFER: begin
        sd_ack[ch] = 1'b1;
        if (is_rd) begin
          if (phase == '0) img_re = mounted;
          if (phase == PH_W'(1)) begin
            sd_buff_wr   = 1'b1;
            sd_buff_dout = mounted ? img_rdata : 8'h00;
          end
        end else if (phase == PH_W'(DIN_LAT) && mounted) begin
          img_we    = 1'b1;
          img_wdata = sd_buff_din[{ch, 3'b000} +: 8];
        end
        if (last_slot) state_nx = RELEASE;
      end
      RELEASE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state        <= IDLE;
      ch           <= '0;
      last         <= CH_W'(NUM_CH - 1);
      lba          <= '0;
      is_rd        <= 1'b0;
      armed        <= '1;
      byte_idx     <= '0;
      phase        <= '0;
      dly_cnt      <= '0;
      sectors_done <= '0;
    end else begin
      state <= state_nx;
      // A channel re-arms only once it has let go of both request lines outside its own transfer.
      for (int n = 0; n < NUM_CH; n++)
        if (!sd_rd[n] && !sd_wr[n] && !(busy && ch == CH_W'(n))) armed[n] <= 1'b1;
      case (state)
        IDLE: if (grant_vld) begin
          ch              <= grant_ch;
          last            <= grant_ch;
          lba             <= sd_lba[{grant_ch, 5'b00000} +: LBA_BITS];
          is_rd           <= sd_rd[grant_ch];
          armed[grant_ch] <= 1'b0;
          dly_cnt         <= DLY_W'(ACK_DELAY - 1);
          byte_idx        <= '0;
          phase           <= '0;
        end
        DELAY: if (dly_cnt != '0) dly_cnt <= dly_cnt - 1'b1;
        XFER: begin
          if (phase == PH_W'(BYTE_DIV - 1)) begin
            phase    <= '0;
            byte_idx <= byte_idx + 1'b1;
          end else begin
            phase <= phase + 1'b1;
          end
        end
        RELEASE: sectors_done <= sectors_done + 32'd1;
        default: ;
      endcase
    end
  end

endmodule
